// File: rtl/lsu_ctrl.sv
// Load/store unit controller: accepts one EX/MEM access at a time, runs the
// data-memory request/response handshake and freezes the pipeline until it completes.
module lsu_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic [6:0]  EXMEM_opcode_out,
    input  logic [2:0]  EXMEM_funct3_out,
    input  logic [31:0] EXMEM_data_addr_out,
    input  logic [31:0] EXMEM_store_data,
    output logic        mem_req,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ready,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        stall,
    output logic [31:0] data_read,
    output logic        load_done,
    output logic        access_err,
    output logic        bus_err
);

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    // Last WAIT count before giving up: the counter reaches 255 after 255 empty WAIT cycles.
    localparam logic [7:0] WAIT_LAST = 8'd254;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t      state, state_next;
    logic        is_load, is_store, funct3_ok, misaligned, legal, illegal;
    logic        load_q;
    logic [7:0]  wait_cnt;
    logic [3:0]  be_next;
    logic [31:0] wdata_next;

    // Access decode; every variable gets a default first.
    // NOTE: assigning every combinational output before any branch prevents latch inference.
    always_comb begin
        is_load    = (EXMEM_opcode_out == OP_LOAD);
        is_store   = (EXMEM_opcode_out == OP_STORE);
        funct3_ok  = 1'b0;
        misaligned = 1'b0;
        be_next    = 4'b1111;
        wdata_next = '0;
        if (is_load)
            funct3_ok = EXMEM_funct3_out inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        else if (is_store)
            funct3_ok = EXMEM_funct3_out inside {3'b000, 3'b001, 3'b010};
        case (EXMEM_funct3_out[1:0])
            2'b01:   misaligned = EXMEM_data_addr_out[0];
            2'b10:   misaligned = (EXMEM_data_addr_out[1:0] != 2'b00);
            default: misaligned = 1'b0;
        endcase
        if (is_store) begin
            case (EXMEM_funct3_out[1:0])
                2'b00: begin
                    be_next    = 4'b0001 << EXMEM_data_addr_out[1:0];
                    wdata_next = {4{EXMEM_store_data[7:0]}};
                end
                2'b01: begin
                    be_next    = 4'b0011 << EXMEM_data_addr_out[1:0];
                    wdata_next = {2{EXMEM_store_data[15:0]}};
                end
                default: begin
                    be_next    = 4'b1111;
                    wdata_next = EXMEM_store_data;
                end
            endcase
        end
        legal   = funct3_ok && !misaligned;
        illegal = (is_load || is_store) && !legal;
    end

    always_comb begin
        state_next = state;
        stall      = 1'b0;
        case (state)
            IDLE: if (legal) begin
                stall      = 1'b1;
                state_next = REQ;
            end
            REQ: begin
                stall = 1'b1;
                if (mem_ready) state_next = load_q ? WAIT : DONE;
            end
            WAIT: begin
                stall = 1'b1;
                if (mem_rvalid || wait_cnt == WAIT_LAST) state_next = DONE;
            end
            default: state_next = IDLE;
        endcase
        if (reset) stall = 1'b0;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop sees pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_be     <= '0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            data_read  <= '0;
            load_done  <= 1'b0;
            access_err <= 1'b0;
            bus_err    <= 1'b0;
            wait_cnt   <= '0;
            load_q     <= 1'b0;
        end else begin
            state      <= state_next;
            access_err <= (state == IDLE) && illegal;
            load_done  <= 1'b0;
            bus_err    <= 1'b0;
            case (state)
                IDLE: if (legal) begin
                    mem_req   <= 1'b1;
                    mem_we    <= is_store;
                    mem_be    <= be_next;
                    mem_addr  <= {EXMEM_data_addr_out[31:2], 2'b00};
                    mem_wdata <= wdata_next;
                    load_q    <= is_load;
                end
                REQ: if (mem_ready) begin
                    mem_req  <= 1'b0;
                    wait_cnt <= '0;
                end
                WAIT: begin
                    if (mem_rvalid) begin
                        data_read <= mem_rdata;
                        load_done <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                        if (wait_cnt == WAIT_LAST) begin
                            data_read <= '0;
                            bus_err   <= 1'b1;
                            load_done <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Randomised scoreboard bench for lsu_ctrl: stimulus pushes expected bus
// events, a negedge monitor pops and compares them as the DUT produces them.
module tb_lsu_ctrl;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_NOP   = 7'b0010011;

    logic        clk = 1'b0;
    logic        reset;
    logic [6:0]  EXMEM_opcode_out;
    logic [2:0]  EXMEM_funct3_out;
    logic [31:0] EXMEM_data_addr_out;
    logic [31:0] EXMEM_store_data;
    logic        mem_req, mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_ready, mem_rvalid;
    logic [31:0] mem_rdata;
    logic        stall;
    logic [31:0] data_read;
    logic        load_done, access_err, bus_err;

    lsu_ctrl dut (
        .clk                 (clk),
        .reset               (reset),
        .EXMEM_opcode_out    (EXMEM_opcode_out),
        .EXMEM_funct3_out    (EXMEM_funct3_out),
        .EXMEM_data_addr_out (EXMEM_data_addr_out),
        .EXMEM_store_data    (EXMEM_store_data),
        .mem_req             (mem_req),
        .mem_we              (mem_we),
        .mem_be              (mem_be),
        .mem_addr            (mem_addr),
        .mem_wdata           (mem_wdata),
        .mem_ready           (mem_ready),
        .mem_rvalid          (mem_rvalid),
        .mem_rdata           (mem_rdata),
        .stall               (stall),
        .data_read           (data_read),
        .load_done           (load_done),
        .access_err          (access_err),
        .bus_err             (bus_err)
    );

    always #5 clk = ~clk;

    typedef enum int {EV_ERR, EV_REQ, EV_LOAD} ev_kind_t;
    typedef struct {
        ev_kind_t    kind;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        berr;
    } ev_t;

    ev_t sb[$];
    int  n_checks = 0;
    int  n_pass   = 0;
    bit  mon_en   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    // Reference rules: legality, lane enables and replicated write data by plain arithmetic.
    function automatic bit legal_access(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] a);
        int  size;
        bit  f3_ok;
        if (op == OP_LOAD)       f3_ok = (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5);
        else if (op == OP_STORE) f3_ok = (f3 <= 2);
        else return 1'b0;
        size = 2 ** (f3 % 4);
        return f3_ok && (a % size == 0);
    endfunction

    function automatic ev_t exp_request(input logic [6:0] op, input logic [2:0] f3,
                                        input logic [31:0] a, input logic [31:0] d);
        ev_t e;
        e.kind  = EV_REQ;
        e.we    = (op == OP_STORE);
        e.addr  = a - (a % 4);
        e.rdata = '0;
        e.berr  = 1'b0;
        e.be    = 4'hF;
        e.wdata = d;
        if (op == OP_STORE && f3 == 0) begin
            e.be    = 4'(1 << (a % 4));
            e.wdata = (d % 256) * 32'h01010101;
        end else if (op == OP_STORE && f3 == 1) begin
            e.be    = 4'(3 << (a % 4));
            e.wdata = (d % 65536) * 32'h00010001;
        end
        return e;
    endfunction

    initial begin : monitor
        ev_t e;
        forever begin
            @(negedge clk);
            if (mon_en && !reset) begin
                if (access_err) begin
                    if (sb.size() == 0) check("spurious access_err", 32'(access_err), 0);
                    else begin
                        e = sb.pop_front();
                        check("access_err event order", 32'(e.kind), 32'(EV_ERR));
                    end
                end
                if (mem_req) begin
                    if (sb.size() == 0 || sb[0].kind != EV_REQ) check("unexpected mem_req", 32'(mem_req), 0);
                    else begin
                        e = sb[0];
                        check("mem_we", 32'(mem_we), 32'(e.we));
                        check("mem_be", 32'(mem_be), 32'(e.be));
                        check("mem_addr", mem_addr, e.addr);
                        if (e.we) check("mem_wdata", mem_wdata, e.wdata);
                        if (mem_ready) void'(sb.pop_front());
                    end
                end
                if (load_done) begin
                    if (sb.size() == 0 || sb[0].kind != EV_LOAD) check("unexpected load_done", 32'(load_done), 0);
                    else begin
                        e = sb.pop_front();
                        check("data_read", data_read, e.rdata);
                        check("bus_err", 32'(bus_err), 32'(e.berr));
                    end
                end else if (bus_err) begin
                    check("bus_err without load_done", 32'(bus_err), 0);
                end
            end
        end
    end

    task automatic drive_nop();
        EXMEM_opcode_out    = OP_NOP;
        EXMEM_funct3_out    = 3'b000;
        EXMEM_data_addr_out = '0;
        EXMEM_store_data    = '0;
    endtask

    // Presents one instruction and plays the memory side; called at posedge+1.
    task automatic run_access(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] a,
                              input logic [31:0] d, input int ready_dly, input int rvalid_dly,
                              input logic [31:0] rdata, input bit timeout);
        bit  is_ld, ok, accepted, done;
        int  stall_cycles, exp_stall, req_cycles, wait_cycles;
        ev_t e;
        is_ld = (op == OP_LOAD);
        ok    = legal_access(op, f3, a);
        EXMEM_opcode_out = op; EXMEM_funct3_out = f3;
        EXMEM_data_addr_out = a; EXMEM_store_data = d;
        if (!ok) begin
            if (op == OP_LOAD || op == OP_STORE) begin
                e = exp_request(op, f3, a, d);
                e.kind = EV_ERR;
                sb.push_back(e);
            end
            @(negedge clk);
            check("stall on non-accepted instruction", 32'(stall), 0);
            @(posedge clk); #1;
            drive_nop();
            return;
        end
        sb.push_back(exp_request(op, f3, a, d));
        if (is_ld) begin
            e = exp_request(op, f3, a, d);
            e.kind  = EV_LOAD;
            e.rdata = timeout ? 32'h0 : rdata;
            e.berr  = timeout;
            sb.push_back(e);
        end
        exp_stall = 2 + ready_dly + (is_ld ? (timeout ? 255 : 1 + rvalid_dly) : 0);
        accepted = 0; done = 0; stall_cycles = 0; req_cycles = 0; wait_cycles = 0;
        for (int cyc = 0; cyc < 1000 && !done; cyc++) begin
            mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = $urandom;
            if (!accepted && mem_req) begin
                mem_ready  = (req_cycles == ready_dly);
                mem_rvalid = 1'($urandom_range(0, 1));
                req_cycles++;
            end else if (accepted && is_ld) begin
                if (!timeout && wait_cycles == rvalid_dly) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = rdata;
                end
                wait_cycles++;
            end
            @(negedge clk);
            if (stall) stall_cycles++;
            else if (cyc > 0) done = 1'b1;
            if (mem_ready && mem_req) accepted = 1'b1;
            @(posedge clk); #1;
        end
        mem_ready = 1'b0; mem_rvalid = 1'b0;
        drive_nop();
        check("access finished within cycle budget", 32'(done), 1);
        check("stall cycle count", stall_cycles, exp_stall);
    endtask

    initial begin : watchdog
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : stimulus
        int          sel;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [31:0] a;
        mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        reset = 1'b1;
        // Legal load present during reset: stall must still stay low.
        EXMEM_opcode_out = OP_LOAD; EXMEM_funct3_out = 3'b010;
        EXMEM_data_addr_out = 32'h100; EXMEM_store_data = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("stall during reset", 32'(stall), 0);
        check("mem_req after reset", 32'(mem_req), 0);
        check("mem_we after reset", 32'(mem_we), 0);
        check("mem_be after reset", 32'(mem_be), 0);
        check("mem_addr after reset", mem_addr, 0);
        check("mem_wdata after reset", mem_wdata, 0);
        check("data_read after reset", data_read, 0);
        check("flags after reset", {29'd0, load_done, access_err, bus_err}, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        drive_nop();
        @(negedge clk);
        check("stall first cycle after reset", 32'(stall), 0);
        @(posedge clk); #1;
        mon_en = 1'b1;

        run_access(OP_LOAD, 3'b010, 32'h100, 32'h0, 0, 1, 32'hDEADBEEF, 0);
        run_access(OP_STORE, 3'b000, 32'h203, 32'h000000A5, 0, 0, 32'h0, 0);
        check("data_read held after store", data_read, 32'hDEADBEEF);
        run_access(OP_STORE, 3'b001, 32'h201, 32'h1234, 0, 0, 32'h0, 0);
        run_access(OP_LOAD, 3'b010, 32'h102, 32'h0, 0, 0, 32'h0, 0);
        run_access(OP_LOAD, 3'b010, 32'h40, 32'h0, 5, 0, 32'hCAFEF00D, 0);

        // Reset lands while a load is waiting for its data; the late rvalid must be ignored.
        EXMEM_opcode_out = OP_LOAD; EXMEM_funct3_out = 3'b010;
        EXMEM_data_addr_out = 32'h80; EXMEM_store_data = '0;
        sb.push_back(exp_request(OP_LOAD, 3'b010, 32'h80, 32'h0));
        @(posedge clk); #1;
        mem_ready = 1'b1;
        @(posedge clk); #1;
        mem_ready = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        drive_nop();
        @(posedge clk); #1;
        reset = 1'b0;
        sb.delete();
        mem_rvalid = 1'b1; mem_rdata = 32'h12345678;
        @(negedge clk);
        check("data_read after reset in WAIT", data_read, 0);
        check("load_done after reset in WAIT", 32'(load_done), 0);
        check("stall after reset in WAIT", 32'(stall), 0);
        check("mem_req after reset in WAIT", 32'(mem_req), 0);
        @(posedge clk); #1;
        mem_rvalid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("data_read after late rvalid", data_read, 0);

        run_access(OP_LOAD, 3'b100, 32'h13, 32'h0, 0, 0, 32'h0, 1);
        check("data_read after timeout", data_read, 0);

        for (int n = 0; n < 150; n++) begin
            sel = $urandom_range(0, 9);
            if (sel < 5)      op = OP_LOAD;
            else if (sel < 9) op = OP_STORE;
            else              op = 7'($urandom);
            f3 = 3'($urandom);
            if (op == OP_STORE && $urandom_range(0, 3) != 0) f3 = 3'($urandom_range(0, 2));
            a = $urandom;
            if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
            run_access(op, f3, a, $urandom, $urandom_range(0, 3), $urandom_range(0, 4), $urandom, 0);
        end

        repeat (5) @(posedge clk);
        #1;
        check("scoreboard drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
